// File: rtl/pri_enc_pkg.sv
// Shared constants and result bundle for the 8-to-3 priority encoder.
package pri_enc_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic             eo;
    logic             gs;
  } enc_res_t;

  // Value seen while disabled or in reset: no index, no group, no cascade.
  localparam enc_res_t RES_IDLE = '{out: 3'b000, eo: 1'b0, gs: 1'b0};

endpackage

// File: rtl/pri_enc8_comb.sv
// Purely combinational priority logic: bit 7 wins, eo cascades when idle.
module pri_enc8_comb
  import pri_enc_pkg::*;
(
  input  logic [IN_W-1:0] in,
  input  logic            ei,
  output enc_res_t        res
);

  // Priority decode of the request vector gated by the enable input
  always_comb begin
    res = RES_IDLE;
    if (ei) begin
      res.gs = (in != 8'h00);
      res.eo = (in == 8'h00);
      casez (in)
        8'b1???_????: res.out = 3'd7;
        8'b01??_????: res.out = 3'd6;
        8'b001?_????: res.out = 3'd5;
        8'b0001_????: res.out = 3'd4;
        8'b0000_1???: res.out = 3'd3;
        8'b0000_01??: res.out = 3'd2;
        8'b0000_001?: res.out = 3'd1;
        default:      res.out = 3'd0;
      endcase
    end else begin
      res = RES_IDLE;
    end
  end

endmodule

// File: rtl/pri_encoder8.sv
// 8-input priority encoder with cascade outputs and an optional output register.
module pri_encoder8
  import pri_enc_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             ei,
  output logic [OUT_W-1:0] out,
  output logic             eo,
  output logic             gs
);

  enc_res_t res_s;
  enc_res_t res_o;

  pri_enc8_comb u_comb (
    .in  (in),
    .ei  (ei),
    .res (res_s)
  );

  if (REG_OUT) begin : g_reg
    enc_res_t res_r;

    // One-cycle output register; reset clears it immediately
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_r <= RES_IDLE;
      end else begin
        res_r <= res_s;
      end
    end

    assign res_o = res_r;
  end else begin : g_comb
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ rst;
    assign res_o            = res_s;
  end

  assign out = res_o.out;
  assign eo  = res_o.eo;
  assign gs  = res_o.gs;

endmodule

// File: tb/tb_pri_encoder8.sv
// Directed and exhaustive checks of pri_encoder8, registered and combinational builds.
module tb_pri_encoder8;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       ei;
  logic [2:0] out_r, out_c;
  logic       eo_r, gs_r, eo_c, gs_c;

  int n_vec;
  int n_err;

  pri_encoder8 #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .in(in), .ei(ei), .out(out_r), .eo(eo_r), .gs(gs_r)
  );

  pri_encoder8 #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in(in), .ei(ei), .out(out_c), .eo(eo_c), .gs(gs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {out,eo,gs}=%b_%b_%b expected %b_%b_%b",
               tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Reference: scan from the top bit down, first set bit wins.
  function automatic logic [4:0] ref_enc(input logic [7:0] v, input logic e);
    if (!e) return 5'b000_0_0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return {3'(i), 1'b0, 1'b1};
    end
    return 5'b000_1_0;
  endfunction

  // Drive one vector; comb build checked at once, registered build after the edge.
  task automatic apply(input logic [7:0] v, input logic e, input logic [4:0] exp, input string tag);
    @(negedge clk);
    in = v;
    ei = e;
    #1;
    check({tag, "/comb"}, {out_c, eo_c, gs_c}, exp);
    check({tag, "/comb_excl"}, {3'b000, gs_c & eo_c, gs_c | eo_c}, {3'b000, 1'b0, e});
    @(posedge clk);
    #1;
    check({tag, "/reg"}, {out_r, eo_r, gs_r}, exp);
    check({tag, "/reg_excl"}, {3'b000, gs_r & eo_r, gs_r | eo_r}, {3'b000, 1'b0, e});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    in    = 8'hA5;
    ei    = 1'b1;
    #12;
    check("reset_state", {out_r, eo_r, gs_r}, 5'b000_0_0);
    @(posedge clk);
    #1;
    check("reset_hold", {out_r, eo_r, gs_r}, 5'b000_0_0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 2: disabled
    apply(8'b0011_1010, 1'b0, 5'b000_0_0, "disabled");

    // Scenario 3: walking one
    apply(8'h01, 1'b1, 5'b000_0_1, "walk0");
    apply(8'h02, 1'b1, 5'b001_0_1, "walk1");
    apply(8'h04, 1'b1, 5'b010_0_1, "walk2");
    apply(8'h08, 1'b1, 5'b011_0_1, "walk3");
    apply(8'h10, 1'b1, 5'b100_0_1, "walk4");
    apply(8'h20, 1'b1, 5'b101_0_1, "walk5");
    apply(8'h40, 1'b1, 5'b110_0_1, "walk6");
    apply(8'h80, 1'b1, 5'b111_0_1, "walk7");

    // Scenario 4: enabled, no request
    apply(8'h00, 1'b1, 5'b000_1_0, "idle");

    // Scenario 5: lower bits ignored
    apply(8'b1010_0010, 1'b1, 5'b111_0_1, "prio_a2");
    apply(8'b0111_0100, 1'b1, 5'b110_0_1, "prio_74");

    // Scenario 1: async reset mid-cycle discards the pending result
    apply(8'hFF, 1'b1, 5'b111_0_1, "pre_reset");
    @(negedge clk);
    in = 8'h10;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {out_r, eo_r, gs_r}, 5'b000_0_0);
    @(posedge clk);
    #1;
    check("reset_held", {out_r, eo_r, gs_r}, 5'b000_0_0);
    @(negedge clk);
    rst = 1'b0;
    in  = 8'h09;
    ei  = 1'b1;
    @(posedge clk);
    #1;
    check("post_release", {out_r, eo_r, gs_r}, 5'b011_0_1);

    // Scenario 6: exhaustive sweep against the reference model
    for (int e = 0; e < 2; e++) begin
      for (int v = 0; v < 256; v++) begin
        apply(8'(v), 1'(e), ref_enc(8'(v), 1'(e)), "sweep");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
